// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state encodings, widths and zero-to-one mapping for the serial link
//
// No ports. Provides:
//   ser_state_t          S0 (idle / waiting for first sample), S1 (capturing)
//   SER_DW/SER_NBW/SER_CW data, bit-count and counter widths
//   ser_nz / ser_nz_nb   treat a zero setting as one
package serial_pkg;

    typedef enum logic {
        S0 = 1'b0,
        S1 = 1'b1
    } ser_state_t;

    localparam int SER_DW  = 256;
    localparam int SER_NBW = 8;
    localparam int SER_CW  = 32;

    function automatic logic [SER_CW-1:0] ser_nz(input logic [SER_CW-1:0] v);
        return (v == '0) ? {{(SER_CW-1){1'b0}}, 1'b1} : v;
    endfunction

    function automatic logic [SER_NBW-1:0] ser_nz_nb(input logic [SER_NBW-1:0] v);
        return (v == '0) ? {{(SER_NBW-1){1'b0}}, 1'b1} : v;
    endfunction

endpackage

// File: rtl/serial_rx_vote.sv
// rtl/serial_rx_vote.sv - 2-of-3 majority over the current and two previous line samples
//
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   x         serial line
//   maj       majority of x now, one clock ago and two clocks ago
module serial_rx_vote (
    input  logic clk,
    input  logic rst,
    input  logic x,
    output logic maj
);

    logic [1:0] hist_q;
    logic [1:0] hist_d;

    always_comb begin
        hist_d = {hist_q[0], x};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= 2'b00;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign maj = (x & hist_q[0]) | (x & hist_q[1]) | (hist_q[0] & hist_q[1]);

endmodule

// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - framed MSB-first serial receiver driven by a shared cnt timebase
//
// Build option: SERIAL_RX_MAJORITY_EN (2-of-3 vote around each sample point).
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   x             serial line, MSB first
//   nbits, n0, n1 data bits, idle counts, counts per bit (0 behaves as 1)
//   cnt           shared timebase, steps by at most 1 per clk
//   data          received word, right-aligned, held until the next frame
//   valid         one-cycle strobe marking new data
//   busy          high while a frame is being captured
module serial_rx
    import serial_pkg::*;
#(
    parameter logic [SER_DW-1:0] P_DATA_INIT = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               x,
    input  logic [SER_NBW-1:0] nbits,
    input  logic [SER_CW-1:0]  n0,
    input  logic [SER_CW-1:0]  n1,
    input  logic [SER_CW-1:0]  cnt,
    output logic [SER_DW-1:0]  data,
    output logic               valid,
    output logic               busy
);

    ser_state_t         state_q, state_d;
    logic [SER_DW-1:0]  sr_q, sr_d;
    logic [SER_NBW-1:0] k_q, k_d;
    logic [SER_CW-1:0]  tgt_q, tgt_d;
    logic [SER_CW-1:0]  n1_q, n1_d;
    logic [SER_NBW-1:0] nb_q, nb_d;
    logic [SER_DW-1:0]  data_q, data_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;

    logic [SER_CW-1:0]  i_n0;
    logic [SER_CW-1:0]  i_n1;
    logic [SER_NBW-1:0] i_nb;
    logic [SER_CW-1:0]  off;
    logic               hit;
    logic               sample;
    logic [SER_DW-1:0]  shifted;

    assign i_n0 = ser_nz(n0);
    assign i_n1 = ser_nz(n1);
    assign i_nb = ser_nz_nb(nbits);
    // Mid-bit sample point relative to the start of each bit window.
    assign off  = 32'd1 + (i_n1 >> 1);

`ifdef SERIAL_RX_MAJORITY_EN
    logic              maj;
    logic [SER_CW-1:0] n1_act;
    logic              use_vote;

    serial_rx_vote u_vote (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .maj (maj)
    );

    // Frozen n1 governs a frame in progress; the live one governs the first bit.
    assign n1_act   = (state_q == S0) ? i_n1 : n1_q;
    assign use_vote = (n1_act >= 32'd3);
    // The vote needs x one count past the target, so the decision lands there.
    assign hit      = use_vote ? (cnt == tgt_q + 32'd1) : (cnt == tgt_q);
    assign sample   = use_vote ? maj : x;
`else
    assign hit    = (cnt == tgt_q);
    assign sample = x;
`endif

    assign shifted = {sr_q[SER_DW-2:0], sample};

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        k_d     = k_q;
        tgt_d   = tgt_q;
        n1_d    = n1_q;
        nb_d    = nb_q;
        data_d  = data_q;
        valid_d = 1'b0;

        case (state_q)
            S0: begin
                n1_d  = i_n1;
                nb_d  = i_nb;
                tgt_d = i_n0 + off;
                sr_d  = '0;
                k_d   = '0;
                if (hit) begin
                    if (i_nb == 8'd1) begin
                        data_d  = {{(SER_DW-1){1'b0}}, sample};
                        valid_d = 1'b1;
                    end else begin
                        sr_d    = {{(SER_DW-1){1'b0}}, sample};
                        tgt_d   = tgt_q + i_n1;
                        k_d     = 8'd1;
                        state_d = S1;
                    end
                end
            end
            S1: begin
                if (hit) begin
                    sr_d  = shifted;
                    tgt_d = tgt_q + n1_q;
                    k_d   = k_q + 8'd1;
                    if (k_q == nb_q - 8'd1) begin
                        data_d  = shifted;
                        valid_d = 1'b1;
                        state_d = S0;
                    end
                end
            end
            default: begin
                state_d = S0;
            end
        endcase

        busy_d = (state_d == S1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S0;
            sr_q    <= '0;
            k_q     <= '0;
            // 1 + off with n0 and n1 taken as 1; the first S0 cycle reloads it.
            tgt_q   <= 32'd2;
            n1_q    <= 32'd1;
            nb_q    <= 8'd1;
            data_q  <= P_DATA_INIT;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            k_q     <= k_d;
            tgt_q   <= tgt_d;
            n1_q    <= n1_d;
            nb_q    <= nb_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_serial_rx.sv
// tb/tb_serial_rx.sv - self-checking bench for serial_rx with a transmitter and receive model
module tb_serial_rx;

    localparam logic [255:0] INIT = 256'hC0FFEE;
`ifdef SERIAL_RX_MAJORITY_EN
    localparam bit           MAJ        = 1'b1;
    localparam logic [255:0] GLITCH_EXP = 256'h0F;
`else
    localparam bit           MAJ        = 1'b0;
    localparam logic [255:0] GLITCH_EXP = 256'h1F;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         x = 1'b0;
    logic [7:0]   nbits = 8'd0;
    logic [31:0]  n0 = 32'd0;
    logic [31:0]  n1 = 32'd0;
    logic [31:0]  cnt = 32'd0;
    logic [255:0] data;
    logic         valid;
    logic         busy;

    serial_rx #(.P_DATA_INIT(INIT)) dut (
        .clk   (clk),
        .rst   (rst),
        .x     (x),
        .nbits (nbits),
        .n0    (n0),
        .n1    (n1),
        .cnt   (cnt),
        .data  (data),
        .valid (valid),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    logic [31:0]  period = 32'd64;
    logic [31:0]  glitch_c = 32'hFFFF_FFFF;
    logic [255:0] payload = '0;
    logic [255:0] pq[$];
    bit           busy_seen = 1'b0;

    function automatic logic [31:0] eff(input logic [31:0] v);
        return (v == 0) ? 32'd1 : v;
    endfunction

    // Transmitter: bit k on the line for cnt in [n0+k*n1+1, n0+(k+1)*n1].
    function automatic logic tx_x(input logic [31:0] c);
        logic [31:0] a0, a1, nb;
        a0 = eff(n0);
        a1 = eff(n1);
        nb = eff({24'd0, nbits});
        if (c >= a0 + 1 && c <= a0 + nb * a1)
            return payload[nb - 1 - (c - a0 - 1) / a1];
        return 1'b0;
    endfunction

    // Receive model: bit k is decided at cnt = n0 + k*n1 + off (+1 when voting).
    logic [255:0] m_acc = '0;
    logic [255:0] e_data = INIT;
    int           m_bits = 0;
    logic         e_valid = 1'b0;
    logic         e_busy = 1'b0;
    logic         xh1 = 1'b0;
    logic         xh2 = 1'b0;

    always @(posedge clk or posedge rst) begin
        logic [31:0] a0, a1, nb, base, pos, k;
        logic        s;
        bit          lat;
        if (rst) begin
            m_acc   = '0;
            m_bits  = 0;
            e_data  = INIT;
            e_valid = 1'b0;
            e_busy  = 1'b0;
            xh1     = 1'b0;
            xh2     = 1'b0;
        end else begin
            a0   = eff(n0);
            a1   = eff(n1);
            nb   = eff({24'd0, nbits});
            lat  = MAJ && (a1 >= 3);
            base = a0 + 32'd1 + (a1 >> 1) + (lat ? 32'd1 : 32'd0);
            pos  = cnt - base;
            k    = pos / a1;
            s    = lat ? ((x + xh1 + xh2) >= 2) : x;
            e_valid = 1'b0;
            if ((pos % a1) == 0 && k < nb) begin
                if (k == 0) begin
                    m_acc  = {255'd0, s};
                    m_bits = 1;
                end else if (k == m_bits) begin
                    m_acc  = {m_acc[254:0], s};
                    m_bits = m_bits + 1;
                end
                if (m_bits == nb) begin
                    e_valid = 1'b1;
                    e_data  = m_acc;
                    m_bits  = 0;
                end
            end
            e_busy = (m_bits > 0);
            xh2 = xh1;
            xh1 = x;
        end
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cnt = (cnt + 1 == period) ? 32'd0 : cnt + 1;
        if (cnt == 0 && pq.size() > 0) payload = pq.pop_front();
        x = tx_x(cnt) ^ (cnt == glitch_c);
        @(negedge clk);
        check("valid", {255'd0, valid}, {255'd0, e_valid});
        check("data", data, e_data);
        check("busy", {255'd0, busy}, {255'd0, e_busy});
        if (busy === 1'b1) busy_seen = 1'b1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        payload = '0;
        cnt     = period - 3;
        x       = 1'b0;
        step();
        check("rst_data", data, INIT);
        check("rst_valid", {255'd0, valid}, 256'd0);
        check("rst_busy", {255'd0, busy}, 256'd0);
        step();
        rst = 1'b0;
    endtask

    task automatic run_until_valid(input int maxc, output bit got,
                                   output logic [31:0] c_at, output logic [255:0] d);
        got  = 1'b0;
        c_at = 32'hFFFF_FFFF;
        d    = '0;
        for (int i = 0; i < maxc; i++) begin
            step();
            if (valid === 1'b1) begin
                got  = 1'b1;
                c_at = cnt;
                d    = data;
                break;
            end
        end
    endtask

    initial begin
        bit           got;
        logic [31:0]  c_at;
        logic [255:0] d;
        logic [255:0] pat;

        // Basic frame 0xA5, repeated after the wrap.
        n0 = 4; n1 = 2; nbits = 8; period = 64;
        pq = '{256'hA5, 256'hA5};
        do_reset();
        run_until_valid(100, got, c_at, d);
        check("basic_got", {255'd0, got}, 256'd1);
        check("basic_cnt", {224'd0, c_at}, 256'd21);
        check("basic_data", d, 256'hA5);
        run_until_valid(100, got, c_at, d);
        check("basic2_got", {255'd0, got}, 256'd1);
        check("basic2_cnt", {224'd0, c_at}, 256'd21);
        check("basic2_data", d, 256'hA5);

        // Minimum settings, then the same with all-zero settings.
        for (int z = 0; z < 2; z++) begin
            n0 = (z == 0) ? 32'd1 : 32'd0;
            n1 = (z == 0) ? 32'd1 : 32'd0;
            nbits = (z == 0) ? 8'd1 : 8'd0;
            period = 8;
            pq = '{256'd1, 256'd0};
            do_reset();
            busy_seen = 1'b0;
            run_until_valid(20, got, c_at, d);
            check("min_got1", {255'd0, got}, 256'd1);
            check("min_cnt1", {224'd0, c_at}, 256'd3);
            check("min_data1", d, 256'd1);
            run_until_valid(20, got, c_at, d);
            check("min_got0", {255'd0, got}, 256'd1);
            check("min_data0", d, 256'd0);
            check("min_busy", {255'd0, busy_seen}, 256'd0);
        end

        // Widest word, alternating pattern.
        pat = {128{2'b01}};
        n0 = 2; n1 = 3; nbits = 255; period = 1024;
        pq = '{pat};
        do_reset();
        run_until_valid(1100, got, c_at, d);
        check("wide_got", {255'd0, got}, 256'd1);
        check("wide_cnt", {224'd0, c_at}, 256'd767 + (MAJ ? 256'd1 : 256'd0));
        check("wide_data", d, pat);
        check("wide_bit255", {255'd0, d[255]}, 256'd0);
        run_until_valid(200, got, c_at, d);
        check("wide_single", {255'd0, got}, 256'd0);

        // Reset in the middle of a 0xBEEF frame, then a clean 0x1234 frame.
        n0 = 4; n1 = 4; nbits = 16; period = 128;
        pq = '{256'hBEEF, 256'h1234};
        do_reset();
        for (int i = 0; i < 200 && cnt != 30; i++) step();
        check("mid_reach", {224'd0, cnt}, 256'd30);
        rst = 1'b1;
        step();
        check("mid_rst_data", data, INIT);
        step();
        rst = 1'b0;
        run_until_valid(300, got, c_at, d);
        check("mid_got", {255'd0, got}, 256'd1);
        check("mid_cnt", {224'd0, c_at}, 256'd68 + (MAJ ? 256'd1 : 256'd0));
        check("mid_data", d, 256'h1234);

        // One-clock glitch on bit 3 of 0x0F.
        n0 = 4; n1 = 5; nbits = 8; period = 64;
        pq = '{256'h0F};
        glitch_c = 32'd22;
        do_reset();
        run_until_valid(100, got, c_at, d);
        check("glitch_got", {255'd0, got}, 256'd1);
        check("glitch_cnt", {224'd0, c_at}, 256'd43 + (MAJ ? 256'd1 : 256'd0));
        check("glitch_data", d, GLITCH_EXP);
        glitch_c = 32'hFFFF_FFFF;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_rx.md
# serial_rx

Capture a word sent MSB first by `serial_tx` and present it as a parallel word with a one-cycle valid strobe. The block is the receive end of the same framing: an idle period of `n0` counts, then `nbits` bits of `n1` counts each. There is no start bit, so framing comes from the shared `cnt` timebase and the same `n0`/`n1`/`nbits` settings the transmitter uses. It sits next to `serial_tx` in loopback benches and on links where both ends share `cnt`.

## Interface
Parameters:
- `P_DATA_INIT`, default 0: reset value of `data`.

Ports:
- `clk`, input, 1: clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `x`, input, 1: serial line, MSB first.
- `nbits`, input, 8: number of data bits. 0 is treated as 1.
- `n0`, input, 32: idle count before the first bit. 0 is treated as 1.
- `n1`, input, 32: counts per bit. 0 is treated as 1.
- `cnt`, input, 32: shared timebase. It must step by at most 1 per `clk`.
- `data`, output reg, 256: received word, right-aligned; bits above `nbits` are 0.
- `valid`, output reg, 1: one-cycle strobe; `data` is new in that cycle.
- `busy`, output reg, 1: high while in S1 (a frame is being captured).

## Operation
- Internal values: `i_n0`, `i_n1` and `i_nb` are the inputs with 0 replaced by 1.
- Sample offset: `off = 1 + (i_n1 >> 1)`.
  - Bit k is sampled at `cnt == n0 + k*n1 + off`.
  - This matches the registered `serial_tx` output, which shows bit k during `cnt` in [n0+k*n1+1, n0+(k+1)*n1].
- All sums are 32-bit and wrap modulo 2^32.
- FSM states:
  - S0 (idle): every cycle, latch `i_n1` and `i_nb`, and set `tgt <= i_n0 + off`, `sr <= 0`, `k <= 0`, `busy <= 0`.
    - When `cnt == tgt`: shift the sample into `sr`, set `tgt <= tgt + i_n1` and `k <= 1`, and go to S1.
  - S1 (capture): latched `n1` and `nbits` are frozen; input changes take effect at the next S0.
    - When `cnt == tgt`: `sr <= {sr[254:0], sample}`, `tgt <= tgt + i_n1`, `k <= k + 1`.
    - When a sample is taken with `k == i_nb - 1`: `data <= {sr[254:0], sample}`, `valid <= 1`, and go to S0.
  - `i_nb == 1`: the S0 sample completes the frame directly. `data = {255'b0, sample}`, `valid <= 1`, and the FSM stays in S0.
  - Default state: go to S0.
- `valid` defaults to 0 every cycle; it is only a strobe.
- `data` holds its value until the next completed frame.
- Frame spacing: after a frame, S0 re-arms on the next `cnt == n0 + off`. This is the same cnt-wrap restart `serial_tx` uses.

## Timing
- Reset values: `data = P_DATA_INIT`, `valid = 0`, `busy = 0`, FSM in S0, `sr = 0`, `k = 0`, `tgt = 1 + off`.
- Latency: `valid` and the new `data` appear on the clock edge at which `cnt` equals the last sample point. They are visible the following cycle.
- Reset mid-frame: the frame is discarded and `valid` is not asserted. The block re-arms at the next `cnt == n0 + off` after reset is released.
- If `cnt` skips a sample value, that sample is missed and the FSM waits for wrap-around. This is legal but yields no frame; the bench must keep `cnt` stepping by at most 1 per clock.
- `nbits` above 255 is not representable (8-bit port), so the maximum word is 255 bits.
- Sampling while `cnt` is held: the sample is taken once, on the first cycle `cnt == tgt`. Because `tgt` advances on that edge, a held `cnt` does not cause repeat sampling.

## Configuration
- `SERIAL_RX_MAJORITY_EN` defined:
  - `sample` is the 2-of-3 majority of `x` at `cnt == tgt-1`, `tgt` and `tgt+1`.
  - The decision, shift, `valid` and state change move to the `tgt+1` cycle, so all outputs are one `cnt` later.
  - Majority voting applies only when `i_n1 >= 3`; otherwise single sampling is used.
- Not defined: `sample = x` at `cnt == tgt`, and there is no extra latency.

## Structure
- Shared package `serial_pkg` holds:
  - state encodings S0 and S1;
  - width constants `SER_DW = 256`, `SER_NBW = 8`, `SER_CW = 32`;
  - the function mapping 0 to 1 for `n0`/`n1`/`nbits`.
- Sub-module `serial_rx_vote` is natural: a 3-tap `x` history with a majority output, instantiated only under `SERIAL_RX_MAJORITY_EN`.

## Test plan
- **Loopback, basic:** `serial_tx` sends `data = 0xA5`, `nbits = 8`, `n0 = 4`, `n1 = 2`; `cnt` counts 0..63 and wraps.
  - Required: `data = 0xA5`, `valid` high for exactly one cycle when `cnt = 21` (last sample at `cnt = 20`).
  - Required: a second 0xA5 frame is received after the wrap.
- **Minimum settings:** `nbits = 1`, `n0 = 1`, `n1 = 1`; send 1, then 0.
  - Required: `data = 1`, then `data = 0`; `busy` stays 0 throughout.
- **Zero inputs:** `nbits = 0`, `n1 = 0`, `n0 = 0`.
  - Required: behaves exactly as `nbits = 1`, `n1 = 1`, `n0 = 1`.
- **Wide word:** `nbits = 255`, `n1 = 3`, alternating pattern 0x...5555.
  - Required: all 255 bits match, bit 255 = 0, exactly one `valid`.
- **Reset mid-frame:** `nbits = 16`, `n1 = 4`; assert `rst` after bit 5 of 0xBEEF.
  - Required: `valid` stays 0; `data = P_DATA_INIT`; the next full frame 0x1234 is received correctly.
- **Majority voting:** with `SERIAL_RX_MAJORITY_EN`, `n1 = 5`, drive a 1-clk inverted glitch on `x` at `cnt == tgt` of bit 3 of 0x0F.
  - Required with the macro: `data = 0x0F`.
  - Required without the macro: `data = 0x1F`.
